// File: rtl/imm_ext_pkg.sv
// Shared types for the pipelined immediate extender.
// Immediate-format select encodings and default width.
package imm_ext_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100,
    IMM_Z = 3'b101
  } immsrc_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate decode and extension.
// Undefined selects yield zero with the illegal flag raised.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [24:0]     i_instr,
  input  logic [2:0]      i_immsrc,
  output logic [XLEN-1:0] o_immext,
  output logic            o_illegal
);

  logic [31:7] w_in;
  logic [31:0] w_imm32;

  assign w_in = i_instr;

  always_comb begin
    w_imm32   = '0;
    o_illegal = 1'b0;
    case (i_immsrc)
      IMM_I: w_imm32 = {{20{w_in[31]}}, w_in[31:20]};
      IMM_S: w_imm32 = {{20{w_in[31]}}, w_in[31:25],
                        w_in[11:7]};
      IMM_B: w_imm32 = {{19{w_in[31]}}, w_in[31], w_in[7],
                        w_in[30:25], w_in[11:8], 1'b0};
      IMM_J: w_imm32 = {{11{w_in[31]}}, w_in[31],
                        w_in[19:12], w_in[20],
                        w_in[30:21], 1'b0};
      IMM_U: w_imm32 = {w_in[31:12], 12'b0};
      IMM_Z: w_imm32 = {27'b0, w_in[19:15]};
      default: o_illegal = 1'b1;
    endcase
  end

  // Z-type has bit 31 clear, so one signed widening serves all forms.
  assign o_immext = XLEN'($signed(w_imm32));

endmodule

// File: rtl/imm_ext_pipe.sv
// One registered stage of immediate extension behind a
// valid/ready handshake with a 2-entry skid buffer.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [24:0]      i_instr,
  input  logic [2:0]       i_immsrc,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_immext,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_ext_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0]  w_imm;
  logic             w_ill;
  logic             w_acc;
  logic             w_drain;

  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_imm;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_ill;

  logic             r_sk_valid;
  logic [XLEN-1:0]  r_sk_imm;
  logic [TAG_W-1:0] r_sk_tag;
  logic             r_sk_ill;

  imm_ext_core #(.XLEN(XLEN)) u_core (
    .i_instr  (i_instr),
    .i_immsrc (i_immsrc),
    .o_immext (w_imm),
    .o_illegal(w_ill)
  );

  assign o_ready   = !r_sk_valid;
  assign w_acc     = i_valid & o_ready;
  assign w_drain   = r_out_valid & i_ready;

  assign o_valid   = r_out_valid;
  assign o_immext  = r_out_imm;
  assign o_tag     = r_out_tag;
  assign o_illegal = r_out_ill;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_imm   <= '0;
      r_out_tag   <= '0;
      r_out_ill   <= 1'b0;
      r_sk_valid  <= 1'b0;
      r_sk_imm    <= '0;
      r_sk_tag    <= '0;
      r_sk_ill    <= 1'b0;
    end else if (i_flush) begin
      r_out_valid <= 1'b0;
      r_sk_valid  <= 1'b0;
    end else if (r_sk_valid) begin
      // o_ready is low here, so only the skid refill can happen.
      if (w_drain) begin
        r_out_imm  <= r_sk_imm;
        r_out_tag  <= r_sk_tag;
        r_out_ill  <= r_sk_ill;
        r_sk_valid <= 1'b0;
      end
    end else if (w_acc) begin
      if (!r_out_valid || i_ready) begin
        r_out_valid <= 1'b1;
        r_out_imm   <= w_imm;
        r_out_tag   <= i_tag;
        r_out_ill   <= w_ill;
      end else begin
        r_sk_valid <= 1'b1;
        r_sk_imm   <= w_imm;
        r_sk_tag   <= i_tag;
        r_sk_ill   <= w_ill;
      end
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Table-driven scoreboard bench for imm_ext_pipe at XLEN 32 and 64.
// Both instances share stimulus; the 32-bit result is the low half.
module tb_imm_ext_pipe;

  typedef struct {
    logic [2:0]  src;
    logic [31:0] ins;
    logic [63:0] e;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  localparam int NV = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [24:0] i_instr = '0;
  logic [2:0]  i_immsrc = '0;
  logic [4:0]  i_tag = '0;
  logic        i_flush = 1'b0;
  logic        i_ready = 1'b1;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32;
  logic [4:0]  tag32;
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64;
  logic [4:0]  tag64;

  vec_t  vec [NV];
  exp_t  q[$];
  int    errors = 0;
  int    checks = 0;
  int    pops = 0;
  int    cur_idx = 0;
  int    cur_tag = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_imm = '0;

  always #5 clk = ~clk;

  imm_ext_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid),
    .o_ready(rdy32), .i_instr(i_instr),
    .i_immsrc(i_immsrc), .i_tag(i_tag),
    .i_flush(i_flush), .o_valid(vld32),
    .i_ready(i_ready), .o_immext(imm32),
    .o_tag(tag32), .o_illegal(ill32)
  );

  imm_ext_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid),
    .o_ready(rdy64), .i_instr(i_instr),
    .i_immsrc(i_immsrc), .i_tag(i_tag),
    .i_flush(i_flush), .o_valid(vld64),
    .i_ready(i_ready), .o_immext(imm64),
    .o_tag(tag64), .o_illegal(ill64)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Handshakes are judged at negedge, where inputs and outputs
  // hold the values the next posedge will act on.
  always @(negedge clk) begin
    exp_t e;
    if (rst || i_flush) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (vld32 && i_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", {59'b0, tag32}, 64'hx);
        end else begin
          e = q.pop_front();
          pops++;
          chk("imm32", {32'b0, imm32}, {32'b0, e.imm[31:0]});
          chk("imm64", imm64, e.imm);
          chk("tag32", {59'b0, tag32}, {59'b0, e.tag});
          chk("tag64", {59'b0, tag64}, {59'b0, e.tag});
          chk("ill32", {63'b0, ill32}, {63'b0, e.ill});
          chk("ill64", {63'b0, ill64}, {63'b0, e.ill});
        end
      end
      if (vld64 && !i_ready) begin
        if (prev_stall) chk("stall_stable", imm64, prev_imm);
        prev_stall = 1'b1;
        prev_imm   = imm64;
      end else begin
        prev_stall = 1'b0;
      end
      if (i_valid && rdy32) begin
        e.imm = vec[cur_idx].e;
        e.tag = cur_tag[4:0];
        e.ill = vec[cur_idx].ill;
        q.push_back(e);
      end
    end
  end

  task automatic drive(input int idx, input int tag);
    logic [31:0] w;
    w        = vec[idx].ins;
    cur_idx  = idx;
    cur_tag  = tag;
    i_valid  = 1'b1;
    i_instr  = w[31:7];
    i_immsrc = vec[idx].src;
    i_tag    = tag[4:0];
  endtask

  task automatic send(input int idx, input int tag);
    logic acc;
    drive(idx, tag);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      acc = rdy32;
      @(posedge clk);
      #1;
      if (acc) return;
    end
    chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vec[0]  = '{3'b000, 32'h8000_0000, 64'hFFFF_FFFF_FFFF_F800, 1'b0};
    vec[1]  = '{3'b001, 32'h8000_0500, 64'hFFFF_FFFF_FFFF_F80A, 1'b0};
    vec[2]  = '{3'b010, 32'h8400_0A00, 64'hFFFF_FFFF_FFFF_F054, 1'b0};
    vec[3]  = '{3'b011, 32'h0150_A000, 64'h0000_0000_0000_A814, 1'b0};
    vec[4]  = '{3'b100, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0};
    vec[5]  = '{3'b100, 32'h1234_5000, 64'h0000_0000_1234_5000, 1'b0};
    vec[6]  = '{3'b101, 32'h000F_8000, 64'h0000_0000_0000_001F, 1'b0};
    vec[7]  = '{3'b111, 32'hFFFF_FFFF, 64'h0, 1'b1};
    vec[8]  = '{3'b110, 32'h1234_5678, 64'h0, 1'b1};
    vec[9]  = '{3'b000, 32'h7FF0_0000, 64'h0000_0000_0000_07FF, 1'b0};
    vec[10] = '{3'b101, 32'h8000_8000, 64'h0000_0000_0000_0001, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", {63'b0, vld32}, 64'd0);
    chk("rst_ready", {63'b0, rdy32}, 64'd1);
    chk("rst_imm32", {32'b0, imm32}, 64'd0);
    chk("rst_imm64", imm64, 64'd0);
    chk("rst_tag", {59'b0, tag64}, 64'd0);
    chk("rst_ill", {63'b0, ill64}, 64'd0);
    @(posedge clk);
    #1;

    send(0, 1);
    i_valid = 1'b0;
    @(negedge clk);
    chk("latency_valid", {63'b0, vld32}, 64'd1);
    @(posedge clk);
    #1;
    idle(2);

    pops = 0;
    for (int i = 1; i < NV; i++) send(i, i + 1);
    idle(3);
    chk("b2b_count", 64'(pops), 64'(NV - 1));
    chk("b2b_drained", 64'(q.size()), 64'd0);

    i_ready = 1'b0;
    send(1, 1);
    send(2, 2);
    drive(3, 3);
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready", {63'b0, rdy32}, 64'd0);
      chk("bp_valid", {63'b0, vld32}, 64'd1);
      chk("bp_tag", {59'b0, tag32}, 64'd1);
    end
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    send(3, 3);
    idle(4);
    chk("bp_drained", 64'(q.size()), 64'd0);
    chk("bp_idle", {63'b0, vld32}, 64'd0);

    for (int pass = 0; pass < 2; pass++) begin
      i_ready = 1'b0;
      send(4, 4);
      send(5, 5);
      drive(7, 6);
      @(negedge clk);
      chk("full_ready", {63'b0, rdy32}, 64'd0);
      if (pass == 0) i_flush = 1'b1;
      else rst = 1'b1;
      @(posedge clk);
      #1;
      i_flush = 1'b0;
      rst     = 1'b0;
      i_valid = 1'b0;
      @(negedge clk);
      chk("fl_valid", {63'b0, vld32}, 64'd0);
      chk("fl_ready", {63'b0, rdy32}, 64'd1);
      if (pass == 1) begin
        chk("rst_mid_imm", imm64, 64'd0);
        chk("rst_mid_tag", {59'b0, tag64}, 64'd0);
      end
      i_ready = 1'b1;
      repeat (4) begin
        @(negedge clk);
        chk("fl_quiet", {63'b0, vld64}, 64'd0);
      end
      @(posedge clk);
      #1;
      send(6, 7 + pass);
      idle(3);
      chk("fl_recover", 64'(q.size()), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
